uart_rx_frame_chk: RTL

Frame checker and buffer that sits directly downstream of `uart_rx`. It consumes each 4-byte received frame (`rcv_done`, `rpd0`..`rpd3`) and validates it as sync byte, command, data and checksum. Each valid {command, data} pair is pushed into a small show-ahead FIFO for the command decoder. The block also keeps good/bad frame counters and a sticky overflow flag.

---
 rtl/uart_rx_frame_chk_if.sv | 30 +++
 rtl/uart_rx_frame_chk.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_chk_if.sv
// Bundle between uart_rx and the frame checker (frame input side) and between
// the checker and the command decoder (FIFO output and status side).
interface uart_rx_frame_chk_if #(
    parameter int CNT_W = 8
);
    logic             rcv_done;
    logic [7:0]       rpd0;
    logic [7:0]       rpd1;
    logic [7:0]       rpd2;
    logic [7:0]       rpd3;
    logic             rd_en;
    logic             clr;
    logic             out_valid;
    logic [7:0]       out_cmd;
    logic [7:0]       out_data;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] bad_cnt;
    logic [1:0]       last_err;
    logic             ovf;

    modport master (
        output rcv_done, rpd0, rpd1, rpd2, rpd3, rd_en, clr,
        input  out_valid, out_cmd, out_data, good_cnt, bad_cnt, last_err, ovf
    );

    modport slave (
        input  rcv_done, rpd0, rpd1, rpd2, rpd3, rd_en, clr,
        output out_valid, out_cmd, out_data, good_cnt, bad_cnt, last_err, ovf
    );
endinterface

// File: rtl/uart_rx_frame_chk.sv
// Validates 4-byte UART frames (sync, cmd, data, checksum) in a two-stage
// pipeline and buffers good {cmd, data} pairs in a show-ahead FIFO.
module uart_rx_frame_chk #(
    parameter logic [7:0] SYNC  = 8'hA5,
    parameter int          DEPTH = 4,
    parameter int          CNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    uart_rx_frame_chk_if.slave bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = CNT_ONE[AW-1:0];
    localparam logic [CNT_W-1:0] FCNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] FCNT_MAX = {CNT_W{1'b1}};

    // The 8-bit result is the 10-bit sum truncated, i.e. the sum mod 256.
    function automatic logic [7:0] checksum8(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [7:0] c);
        return a + b + c;
    endfunction

    logic             rcv_d_q;
    logic [7:0]       cap0_q, cap1_q, cap2_q, cap3_q;
    logic             cap_vld_q;
    logic [15:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
    logic [1:0]       last_err_q, last_err_d;
    logic             ovf_q, ovf_d;

    logic frame_evt_s, sync_err_s, sum_err_s, out_valid_s;
    logic pop_s, push_ok_s, good_s, bad_s, push_s, drop_s;

    assign frame_evt_s = bus.rcv_done & ~rcv_d_q;
    assign sync_err_s  = (cap0_q != SYNC);
    assign sum_err_s   = (cap3_q != checksum8(cap0_q, cap1_q, cap2_q));
    assign out_valid_s = (count_q != {(AW+1){1'b0}});
    assign pop_s       = bus.rd_en & out_valid_s;
    assign push_ok_s   = (count_q < DEPTH_C) | pop_s;
    assign good_s      = cap_vld_q & ~sync_err_s & ~sum_err_s;
    assign bad_s       = cap_vld_q & (sync_err_s | sum_err_s);
    assign push_s      = good_s & push_ok_s;
    assign drop_s      = good_s & ~push_ok_s;

    // Next-state for FIFO pointers, occupancy and status counters.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        last_err_d = last_err_q;
        ovf_d      = ovf_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // clr wins over any same-cycle status update.
        if (bus.clr) begin
            good_cnt_d = {CNT_W{1'b0}};
            bad_cnt_d  = {CNT_W{1'b0}};
            last_err_d = 2'b00;
            ovf_d      = 1'b0;
        end else begin
            if (push_s && (good_cnt_q != FCNT_MAX)) begin
                good_cnt_d = good_cnt_q + FCNT_ONE;
            end else begin
                good_cnt_d = good_cnt_q;
            end
            if (bad_s) begin
                last_err_d = {sync_err_s, sum_err_s};
                if (bad_cnt_q != FCNT_MAX) begin
                    bad_cnt_d = bad_cnt_q + FCNT_ONE;
                end else begin
                    bad_cnt_d = bad_cnt_q;
                end
            end else begin
                last_err_d = last_err_q;
                bad_cnt_d  = bad_cnt_q;
            end
            if (drop_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // Edge detect and capture stage; rcv_d resets high to ignore a held level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcv_d_q   <= 1'b1;
            cap_vld_q <= 1'b0;
            cap0_q    <= 8'h00;
            cap1_q    <= 8'h00;
            cap2_q    <= 8'h00;
            cap3_q    <= 8'h00;
        end else begin
            rcv_d_q   <= bus.rcv_done;
            cap_vld_q <= frame_evt_s;
            if (frame_evt_s) begin
                cap0_q <= bus.rpd0;
                cap1_q <= bus.rpd1;
                cap2_q <= bus.rpd2;
                cap3_q <= bus.rpd3;
            end
        end
    end

    // FIFO storage, pointers and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            good_cnt_q <= {CNT_W{1'b0}};
            bad_cnt_q  <= {CNT_W{1'b0}};
            last_err_q <= 2'b00;
            ovf_q      <= 1'b0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= {cap1_q, cap2_q};
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            last_err_q <= last_err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_s;
    assign bus.out_cmd   = mem_q[rd_ptr_q][15:8];
    assign bus.out_data  = mem_q[rd_ptr_q][7:0];
    assign bus.good_cnt  = good_cnt_q;
    assign bus.bad_cnt   = bad_cnt_q;
    assign bus.last_err  = last_err_q;
    assign bus.ovf       = ovf_q;
endmodule
